// File: rtl/mem_pkg.sv
// Shared types and defaults for the burst master: FSM encoding, default sizes, write pattern seed.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEF_WIDTH        = 8;
    localparam int         DEF_DEPTH        = 16;
    localparam logic [7:0] DEF_PATTERN_BASE = 8'h3C;

endpackage

// File: rtl/mem_burst_master_if.sv
// Command, memory and read-return bundle of the burst master; master drives m_*, cmd_ready and status.
// With MEM_BURST_MASTER_CHECK_EN the bundle also carries the read comparator results.
interface mem_burst_master_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH:0]   cmd_len;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_wr_rd;
    logic [WIDTH-1:0]      m_wdata;
    logic                  m_valid;
    logic [WIDTH-1:0]      m_rdata;
    logic                  m_ready;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic                  done;
`ifdef MEM_BURST_MASTER_CHECK_EN
    logic                  mismatch;
    logic [7:0]            err_cnt;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, m_rdata, m_ready,
        output cmd_ready, m_addr, m_wr_rd, m_wdata, m_valid, rd_data, rd_valid, busy, done,
               mismatch, err_cnt
    );
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, m_rdata, m_ready,
        input  cmd_ready, m_addr, m_wr_rd, m_wdata, m_valid, rd_data, rd_valid, busy, done,
               mismatch, err_cnt
    );
`else
    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, m_rdata, m_ready,
        output cmd_ready, m_addr, m_wr_rd, m_wdata, m_valid, rd_data, rd_valid, busy, done
    );
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, m_rdata, m_ready,
        input  cmd_ready, m_addr, m_wr_rd, m_wdata, m_valid, rd_data, rd_valid, busy, done
    );
`endif
endinterface

// File: rtl/mem_burst_addr_gen.sv
// Burst address/beat counter: loads on command accept, steps on each handshake, flags the last beat.
// Registered outputs; last_o is decoded from the registered beat and length.
module mem_burst_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH:0]   beat_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   beat_q, beat_d;
    logic [ADDR_WIDTH:0]   len_q,  len_d;

    // DEPTH is a power of two, so the natural counter overflow is the wrap.
    always_comb begin
        addr_d = addr_q;
        beat_d = beat_q;
        len_d  = len_q;
        if (load_i) begin
            addr_d = start_addr_i;
            beat_d = '0;
            len_d  = len_i;
        end else if (step_i) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            beat_d = beat_q + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            addr_q <= '0;
            beat_q <= '0;
            len_q  <= '0;
        end else begin
            addr_q <= addr_d;
            beat_q <= beat_d;
            len_q  <= len_d;
        end
    end

    assign addr_o = addr_q;
    assign beat_o = beat_q;
    assign last_o = (beat_q == len_q - (ADDR_WIDTH+1)'(1));

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator: one access per beat, first m_valid the cycle after accept, rd_* one cycle after a read beat.
// Stalls on m_ready low; one command at a time. Optional read checker: MEM_BURST_MASTER_CHECK_EN.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int         WIDTH        = DEF_WIDTH,
    parameter int         DEPTH        = DEF_DEPTH,
    parameter int         ADDR_WIDTH   = $clog2(DEPTH),
    parameter logic [7:0] PATTERN_BASE = DEF_PATTERN_BASE
) (
    input  logic               clk,
    input  logic               res,
    mem_burst_master_if.master bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [WIDTH-1:0]    PAT     = WIDTH'(PATTERN_BASE);

    state_t              state_q;
    logic                cmd_ready_q;
    logic                m_valid_q;
    logic                m_wr_rd_q;
    logic [WIDTH-1:0]    m_wdata_q;
    logic [WIDTH-1:0]    rd_data_q;
    logic                rd_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                accept;
    logic                hs;
    logic                last;
    logic [ADDR_WIDTH:0] eff_len;
    logic [ADDR_WIDTH:0] beat;

    assign accept  = bus.cmd_valid && cmd_ready_q;
    assign hs      = m_valid_q && bus.m_ready;
    assign eff_len = (bus.cmd_len > DEPTH_L) ? DEPTH_L : bus.cmd_len;

    mem_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk          (clk),
        .res          (res),
        .load_i       (accept),
        .step_i       (hs),
        .start_addr_i (bus.cmd_addr),
        .len_i        (eff_len),
        .addr_o       (bus.m_addr),
        .beat_o       (beat),
        .last_o       (last)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            m_valid_q   <= 1'b0;
            m_wr_rd_q   <= 1'b0;
            m_wdata_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= hs && !m_wr_rd_q;
            if (hs && !m_wr_rd_q) begin
                rd_data_q <= bus.m_rdata;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        m_wr_rd_q   <= bus.cmd_wr;
                        m_wdata_q   <= PAT;
                        cmd_ready_q <= 1'b0;
                        if (eff_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            m_valid_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (hs) begin
                        // Next beat's pattern is base + post-increment beat count.
                        m_wdata_q <= PAT + WIDTH'(beat) + WIDTH'(1);
                        if (last) begin
                            state_q   <= DONE;
                            m_valid_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    m_valid_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_wr_rd   = m_wr_rd_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef MEM_BURST_MASTER_CHECK_EN
    logic       mismatch_q;
    logic [7:0] err_cnt_q;
    logic       bad_beat;

    assign bad_beat = hs && !m_wr_rd_q && (bus.m_rdata != (PAT + WIDTH'(beat)));

    always_ff @(posedge clk) begin
        if (res) begin
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            mismatch_q <= bad_beat;
            if (accept) begin
                err_cnt_q <= '0;
            end else if (bad_beat && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.mismatch = mismatch_q;
    assign bus.err_cnt  = err_cnt_q;
`endif

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Synthesizable initiator for the team's single-port memory valid/ready interface (addr, wr_rd, wdata, rdata, valid, ready).
- Accepts one burst command at a time: write or read, start address, length.
- Issues one memory access per beat with a valid/ready handshake.
- Write data is a deterministic incrementing pattern. Read data is forwarded on a pulse-qualified output.
- Replaces testbench front-door tasks in the system-level environment and in BIST.

Parameters:
- WIDTH, 8, memory data width.
- DEPTH, 16, number of memory locations; must be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- PATTERN_BASE, 8'h3C, write pattern value for beat 0; truncated or zero-extended to WIDTH.

Ports:
- clk  input  1  clock; all logic on posedge.
- res  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master idle and able to accept a command.
- cmd_wr  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_WIDTH  start address.
- cmd_len  input  ADDR_WIDTH+1  number of beats, 0..DEPTH.
- m_addr  output  ADDR_WIDTH  memory address.
- m_wr_rd  output  1  memory direction (1 = write).
- m_wdata  output  WIDTH  memory write data.
- m_valid  output  1  memory request valid.
- m_rdata  input  WIDTH  memory read data; sampled when m_valid && m_ready && !m_wr_rd.
- m_ready  input  1  memory accepts/completes the current beat.
- rd_data  output  WIDTH  captured read data.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst end.

Behaviour:
- Reset (res=1 at posedge): state IDLE.
  - cmd_ready=1.
  - m_valid=0, m_wr_rd=0, m_addr=0, m_wdata=0.
  - rd_data=0, rd_valid=0, busy=0, done=0.
  - Beat counter = 0.
  - Reset mid-burst abandons the burst immediately: no done pulse, m_valid low on the next cycle.
- FSM states: IDLE, REQ, DONE.
- IDLE: cmd_ready=1. Command accepted on cmd_valid && cmd_ready.
  - Latches cmd_wr, cmd_addr, and effective length. Effective length = min(cmd_len, DEPTH).
  - If effective length = 0: go to DONE directly with no memory access; done pulses the next cycle.
  - Otherwise go to REQ. First m_valid=1 appears on the cycle after acceptance.
- REQ: m_valid=1. m_addr, m_wr_rd and m_wdata are held stable until handshake (m_valid && m_ready at posedge).
  - On handshake:
    - Beat counter increments.
    - m_addr increments modulo DEPTH: DEPTH-1 wraps to 0.
    - m_wdata = PATTERN_BASE + beat (mod 2^WIDTH).
  - Last beat: go to DONE, m_valid=0 next cycle.
  - Otherwise stay in REQ with m_valid held high. Back-to-back beats give one beat per cycle when m_ready stays 1.
  - m_ready while m_valid=0 is ignored.
- Read beats: rd_data<=m_rdata and rd_valid=1 the cycle after each read handshake (1-cycle latency). No backpressure on rd_*.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. cmd_ready stays 0 in DONE, so a new command is accepted at the earliest one cycle after done.
- busy=1 in REQ only. cmd_ready=1 in IDLE only. Commands arriving while busy are not accepted; cmd_valid must be held.
- Write pattern restarts at PATTERN_BASE for every command.

Optional Feature:
- Macro MEM_BURST_MASTER_CHECK_EN.
- Defined:
  - On each read handshake, compare m_rdata with PATTERN_BASE+beat.
  - Extra outputs mismatch (1-cycle pulse aligned with rd_valid) and err_cnt (8-bit, saturating at 255).
  - err_cnt clears on res and on each command acceptance.
- Undefined: no comparator; mismatch/err_cnt ports and logic absent.

Decomposition:
- Shared package mem_pkg: FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2), default WIDTH/DEPTH, PATTERN_BASE.
- One natural sub-module: mem_burst_addr_gen, holding the address/beat counter, wrap logic and last-beat flag.
- Comparator stays inline under the macro.

Test Plan:
- Write burst: addr=0, len=16, m_ready tied 1 → 16 consecutive m_valid cycles; m_wdata 3C,3D…4B; addr 0..15; done pulses once; memory contents match.
- Read burst: addr=0, len=16 after that write → rd_valid 16 pulses with rd_data 3C..4B; with CHECK_EN, err_cnt=0.
- Wrap: write addr=14, len=4 → m_addr 14,15,0,1; data 3C..3F.
- Backpressure: m_ready low 3 cycles on beat 2 → m_addr/m_wdata stable across the stall; no beat lost or duplicated; total handshakes = len.
- Edge lengths: cmd_len=0 → no m_valid, done on next cycle. cmd_len=20 → exactly 16 beats.
- Reset mid-burst: res at beat 5 of 16 → next cycle m_valid=0, busy=0, done never pulses; a new command is accepted normally. With CHECK_EN, a corrupted location gives mismatch=1 and err_cnt=1.
